// File: rtl/des_decrypt_stream_pkg.sv
// Shared types and constants for the DES stream engines.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package des_stream_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] DES_LAST_ROUND = 4'd15;

    typedef logic [63:0] des_block_t;

endpackage

// File: rtl/des_decrypt_stream_if.sv
// 64-bit valid/ready stream bundle shared by the ciphertext and plaintext sides.
// Latency: n/a (wiring only).
// Backpressure: a beat transfers on a cycle where tvalid and tready are both high.
interface des_decrypt_stream_if;
    import des_stream_pkg::*;

    des_block_t tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/des_decrypt_stream_fifo.sv
// Generic registered FIFO with valid/ready on both sides and an occupancy count.
// Latency: a push is visible at the head one cycle after the push edge.
// Backpressure: push_rdy drops when full; head holds while pop_vld && !pop_rdy.
module stream_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     push_vld,
    output logic                     push_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [$clog2(DEPTH):0]   count
);
    // DEPTH is a power of two >= 2, so pointers wrap naturally at AW bits.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign push_rdy = (count < FULL);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage is not reset; a flush only clears the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/des_decrypt_stream.sv
// Sequences a round-iterative DES core in decrypt mode over a ciphertext stream.
// Latency: accept edge T, 16 round cycles, plaintext pushed at T+16; one block per 17 cycles max.
// Backpressure: input ready only in IDLE with a free output FIFO slot; output FIFO absorbs stalls.
module des_decrypt_stream
    import des_stream_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [55:0]                  key56,
    des_decrypt_stream_if.slave          s_axis,
    des_decrypt_stream_if.master         m_axis,
    output logic [55:0]                  des_key,
    output logic                         des_decrypt,
    output logic [3:0]                   des_round_sel,
    output des_block_t                   des_in,
    input  des_block_t                   des_out,
    output logic                         busy,
    output logic [CNT_W-1:0]             blocks_done
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;

    state_t        state;
    state_t        state_nxt;
    logic          s_rdy;
    logic          accept;
    logic          last_round;
    logic          fifo_in_rdy;
    logic          fifo_out_vld;
    des_block_t    fifo_out_dat;
    logic [CW-1:0] fifo_count;

    assign des_decrypt   = 1'b1;
    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = fifo_out_vld;
    assign m_axis.tdata  = fifo_out_dat;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake decode; ready never looks at tvalid.
    always_comb begin
        state_nxt  = state;
        s_rdy      = 1'b0;
        accept     = 1'b0;
        busy       = 1'b0;
        last_round = 1'b0;
        case (state)
            ST_IDLE: begin
                s_rdy  = !rst && fifo_in_rdy;
                accept = s_rdy && s_axis.tvalid;
                if (accept) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (des_round_sel == DES_LAST_ROUND) begin
                    last_round = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Block operands, round counter and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            des_in        <= '0;
            des_key       <= '0;
            des_round_sel <= '0;
            blocks_done   <= '0;
        end else if (accept) begin
            des_in        <= s_axis.tdata;
            des_key       <= key56;
            des_round_sel <= '0;
        end else if (last_round) begin
            des_round_sel <= '0;
            blocks_done   <= blocks_done + CNT_W'(1);
        end else if (busy) begin
            des_round_sel <= des_round_sel + 4'd1;
        end
    end

    // A free slot was required to enter RUN, so the final-round push always fits.
    stream_fifo #(
        .WIDTH (64),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_dat (des_out),
        .push_vld (last_round),
        .push_rdy (fifo_in_rdy),
        .pop_dat  (fifo_out_dat),
        .pop_vld  (fifo_out_vld),
        .pop_rdy  (m_axis.tready),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_des_decrypt_stream.sv
// Directed bench for des_decrypt_stream with a table-driven stand-in for the DES core.
// Latency: checks the accept-to-push timing and round sequencing cycle by cycle.
// Backpressure: exercises a full output FIFO, simultaneous push/pop and mid-block reset.
module tb_des_decrypt_stream;

    localparam logic [63:0] K1_64 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2_64 = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1 = 64'h3FA40E8A984D4815, P1 = 64'h4E6F772069732074;
    localparam logic [63:0] C2 = 64'h6A271787AB8883F9, P2 = 64'h68652074696D6520;
    localparam logic [63:0] C3 = 64'h893D51EC4B563B53, P3 = 64'h666F7220616C6C20;
    localparam logic [63:0] C4 = 64'h85E813540F0AB405, P4 = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] key56;
    logic [55:0] des_key;
    logic        des_decrypt;
    logic [3:0]  des_round_sel;
    logic [63:0] des_in;
    logic [63:0] des_out;
    logic        busy;
    logic [15:0] blocks_done;
    logic [55:0] k1, k2;

    int vectors     = 0;
    int miscompares = 0;

    des_decrypt_stream_if s_if ();
    des_decrypt_stream_if m_if ();

    des_decrypt_stream #(.OUT_DEPTH(2), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .key56         (key56),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .des_key       (des_key),
        .des_decrypt   (des_decrypt),
        .des_round_sel (des_round_sel),
        .des_in        (des_in),
        .des_out       (des_out),
        .busy          (busy),
        .blocks_done   (blocks_done)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] strip_parity(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[55-7*i -: 7] = k[63-8*i -: 7];
        return r;
    endfunction

    // Stand-in for des_o: known FIPS-81 decrypt results, valid only in the last round.
    always_comb begin
        des_out = des_in ^ 64'hA5A5_A5A5_A5A5_A5A5;
        if (des_round_sel == 4'd15 && des_decrypt) begin
            des_out = ~des_in;
            if (des_key == k1 && des_in == C1) des_out = P1;
            if (des_key == k1 && des_in == C2) des_out = P2;
            if (des_key == k1 && des_in == C3) des_out = P3;
            if (des_key == k2 && des_in == C4) des_out = P4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d);
        int n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        while (!s_if.tready && n < 100) begin tick(); n++; end
        vectors++;
        if (s_if.tready !== 1'b1) begin miscompares++; $display("FAIL send_timeout: tready=%b after %0d cycles, want 1", s_if.tready, n); end
        tick();
        s_if.tvalid = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [63:0] exp);
        int n = 0;
        m_if.tready = 1'b1;
        while (!m_if.tvalid && n < 60) begin tick(); n++; end
        vectors++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp) begin miscompares++; $display("FAIL %s: tvalid=%b tdata=%h, want 1 %h", name, m_if.tvalid, m_if.tdata, exp); end
        tick();
        m_if.tready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++; if (s_if.tready !== 1'b0) begin miscompares++; $display("FAIL rst_s_tready: got %b want 0", s_if.tready); end
        vectors++; if (m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid: got %b want 0", m_if.tvalid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (blocks_done !== 16'd0) begin miscompares++; $display("FAIL rst_blocks_done: got %0d want 0", blocks_done); end
        vectors++; if (des_round_sel !== 4'd0) begin miscompares++; $display("FAIL rst_round_sel: got %0d want 0", des_round_sel); end
        vectors++; if (des_in !== 64'd0 || des_key !== 56'd0) begin miscompares++; $display("FAIL rst_operands: des_in=%h des_key=%h want 0 0", des_in, des_key); end
        vectors++; if (des_decrypt !== 1'b1) begin miscompares++; $display("FAIL rst_decrypt: got %b want 1", des_decrypt); end
        rst = 1'b0;
        tick();
        vectors++; if (s_if.tready !== 1'b1) begin miscompares++; $display("FAIL idle_s_tready: got %b want 1", s_if.tready); end
    endtask

    task automatic test_single_block();
        key56 = k1;
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = C1;
        vectors++; if (s_if.tready !== 1'b1) begin miscompares++; $display("FAIL single_accept_rdy: got %b want 1", s_if.tready); end
        tick();
        s_if.tvalid = 1'b0;
        for (int r = 0; r < 16; r++) begin
            vectors++; if (des_round_sel !== 4'(r)) begin miscompares++; $display("FAIL round_sel: got %0d want %0d", des_round_sel, r); end
            vectors++; if (busy !== 1'b1 || s_if.tready !== 1'b0) begin miscompares++; $display("FAIL run_flags r%0d: busy=%b s_tready=%b want 1 0", r, busy, s_if.tready); end
            vectors++; if (des_in !== C1 || des_key !== k1 || des_decrypt !== 1'b1) begin miscompares++; $display("FAIL run_operands r%0d: des_in=%h des_key=%h dec=%b", r, des_in, des_key, des_decrypt); end
            vectors++; if (m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL early_tvalid r%0d: got %b want 0", r, m_if.tvalid); end
            tick();
        end
        vectors++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== P1) begin miscompares++; $display("FAIL single_out: tvalid=%b tdata=%h want 1 %h", m_if.tvalid, m_if.tdata, P1); end
        vectors++; if (blocks_done !== 16'd1) begin miscompares++; $display("FAIL single_blocks_done: got %0d want 1", blocks_done); end
        vectors++; if (busy !== 1'b0 || des_round_sel !== 4'd0) begin miscompares++; $display("FAIL single_idle: busy=%b round_sel=%0d want 0 0", busy, des_round_sel); end
        tick();
        vectors++; if (m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL single_drained: tvalid=%b want 0", m_if.tvalid); end
        m_if.tready = 1'b0;
    endtask

    task automatic test_back_pressure();
        key56 = k1;
        m_if.tready = 1'b0;
        send_word(C1);
        send_word(C2);
        repeat (16) tick();
        s_if.tvalid = 1'b1;
        s_if.tdata  = C3;
        for (int i = 0; i < 10; i++) begin
            vectors++; if (s_if.tready !== 1'b0) begin miscompares++; $display("FAIL bp_s_tready c%0d: got %b want 0", i, s_if.tready); end
            vectors++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== P1) begin miscompares++; $display("FAIL bp_hold c%0d: tvalid=%b tdata=%h want 1 %h", i, m_if.tvalid, m_if.tdata, P1); end
            tick();
        end
        vectors++; if (blocks_done !== 16'd3) begin miscompares++; $display("FAIL bp_blocks_done: got %0d want 3", blocks_done); end
        m_if.tready = 1'b1;
        tick();
        m_if.tready = 1'b0;
        vectors++; if (s_if.tready !== 1'b1 || m_if.tdata !== P2) begin miscompares++; $display("FAIL bp_freed: s_tready=%b head=%h want 1 %h", s_if.tready, m_if.tdata, P2); end
        tick();
        s_if.tvalid = 1'b0;
        vectors++; if (busy !== 1'b1 || des_in !== C3) begin miscompares++; $display("FAIL bp_third_accept: busy=%b des_in=%h want 1 %h", busy, des_in, C3); end
        pop_expect("bp_order_2", P2);
        pop_expect("bp_order_3", P3);
    endtask

    task automatic test_simultaneous();
        key56 = k1;
        m_if.tready = 1'b0;
        send_word(C1);
        repeat (16) tick();
        vectors++; if (dut.fifo_count !== 2'd1) begin miscompares++; $display("FAIL sim_pre_count: got %0d want 1", dut.fifo_count); end
        send_word(C2);
        repeat (15) tick();
        vectors++; if (des_round_sel !== 4'd15 || m_if.tdata !== P1) begin miscompares++; $display("FAIL sim_pre_edge: round_sel=%0d head=%h want 15 %h", des_round_sel, m_if.tdata, P1); end
        m_if.tready = 1'b1;
        tick();
        m_if.tready = 1'b0;
        vectors++; if (dut.fifo_count !== 2'd1) begin miscompares++; $display("FAIL sim_count: got %0d want 1", dut.fifo_count); end
        vectors++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== P2) begin miscompares++; $display("FAIL sim_head: tvalid=%b tdata=%h want 1 %h", m_if.tvalid, m_if.tdata, P2); end
        vectors++; if (blocks_done !== 16'd6) begin miscompares++; $display("FAIL sim_blocks_done: got %0d want 6", blocks_done); end
        pop_expect("sim_drain", P2);
        vectors++; if (m_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL sim_empty: tvalid=%b want 0", m_if.tvalid); end
    endtask

    task automatic test_key_change();
        key56 = k1;
        m_if.tready = 1'b0;
        send_word(C1);
        repeat (5) tick();
        key56 = k2;
        tick();
        vectors++; if (des_key !== k1) begin miscompares++; $display("FAIL key_held: got %h want %h", des_key, k1); end
        pop_expect("key_old_block", P1);
        send_word(C4);
        vectors++; if (des_key !== k2) begin miscompares++; $display("FAIL key_new_latched: got %h want %h", des_key, k2); end
        pop_expect("key_new_block", P4);
        vectors++; if (blocks_done !== 16'd8) begin miscompares++; $display("FAIL key_blocks_done: got %0d want 8", blocks_done); end
    endtask

    task automatic test_reset_mid_run();
        logic stray = 1'b0;
        key56 = k1;
        m_if.tready = 1'b0;
        send_word(C1);
        repeat (16) tick();
        vectors++; if (m_if.tvalid !== 1'b1) begin miscompares++; $display("FAIL mrst_unread: tvalid=%b want 1", m_if.tvalid); end
        send_word(C2);
        repeat (7) tick();
        vectors++; if (des_round_sel !== 4'd7) begin miscompares++; $display("FAIL mrst_round7: got %0d want 7", des_round_sel); end
        rst = 1'b1;
        tick();
        vectors++; if (m_if.tvalid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mrst_flags: tvalid=%b busy=%b want 0 0", m_if.tvalid, busy); end
        vectors++; if (blocks_done !== 16'd0 || des_round_sel !== 4'd0) begin miscompares++; $display("FAIL mrst_counters: blocks_done=%0d round_sel=%0d want 0 0", blocks_done, des_round_sel); end
        vectors++; if (des_in !== 64'd0 || des_key !== 56'd0 || s_if.tready !== 1'b0) begin miscompares++; $display("FAIL mrst_regs: des_in=%h des_key=%h s_tready=%b", des_in, des_key, s_if.tready); end
        rst = 1'b0;
        m_if.tready = 1'b1;
        repeat (30) begin
            tick();
            if (m_if.tvalid) stray = 1'b1;
        end
        m_if.tready = 1'b0;
        vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL mrst_stray: saw tvalid=%b after release, want 0", stray); end
        vectors++; if (s_if.tready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mrst_idle: s_tready=%b busy=%b want 1 0", s_if.tready, busy); end
    endtask

    initial begin
        rst         = 1'b1;
        key56       = '0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        k1 = strip_parity(K1_64);
        k2 = strip_parity(K2_64);
        test_reset();
        test_single_block();
        test_back_pressure();
        test_simultaneous();
        test_key_change();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
